// File: rtl/ddc_plan_pkg.sv
// Shared constants and types for the DDC channel-plan scheduler.
package ddc_plan_pkg;

    localparam int unsigned N_PLAN = 128;
    localparam int unsigned K_W    = 14;
    localparam int unsigned IDX_W  = 7;
    localparam int unsigned LEN_W  = 8;

    typedef logic [LEN_W-1:0] plan_len_t;
    typedef logic [K_W-1:0]   plan_k_t;
    typedef logic [IDX_W-1:0] plan_idx_t;

    // Scheduler state encoding: IDLE until the first swap, RUN afterwards.
    typedef logic [0:0] plan_state_t;
    localparam plan_state_t ST_IDLE = 1'b0;
    localparam plan_state_t ST_RUN  = 1'b1;

endpackage

// File: rtl/ddc_plan_sched_if.sv
// Configuration, stream and status signals between software/datapath and the scheduler.
interface ddc_plan_sched_if;
    import ddc_plan_pkg::*;

    logic      cfg_wr;
    plan_k_t   cfg_k;
    logic      cfg_clear;
    logic      cfg_commit;
    logic      valid_in;
    plan_k_t   k_in;

    logic      hit_valid;
    plan_idx_t hit_index;
    logic      running;
    logic      swap_pending;
    plan_len_t shadow_len;
    plan_len_t active_len;
    logic      ovf_err;
    logic      order_err;

    modport master (
        output cfg_wr, cfg_k, cfg_clear, cfg_commit, valid_in, k_in,
        input  hit_valid, hit_index, running, swap_pending,
        input  shadow_len, active_len, ovf_err, order_err
    );

    modport slave (
        input  cfg_wr, cfg_k, cfg_clear, cfg_commit, valid_in, k_in,
        output hit_valid, hit_index, running, swap_pending,
        output shadow_len, active_len, ovf_err, order_err
    );

endinterface

// File: rtl/ddc_plan_bank.sv
// One plan bank: N_PLAN x K_W storage, synchronous write, asynchronous read.
module ddc_plan_bank
    import ddc_plan_pkg::*;
(
    input  logic      clk_i,
    input  logic      we_i,
    input  plan_idx_t waddr_i,
    input  plan_k_t   wdata_i,
    input  plan_idx_t raddr_i,
    output plan_k_t   rdata_c_o
);

    plan_k_t mem_q [N_PLAN];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_c_o = mem_q[raddr_i];

endmodule

// File: rtl/ddc_plan_sched.sv
// Double-buffered per-frame channel-plan scheduler: loads a shadow plan, swaps it in at
// a frame boundary and reports the output slot of each scheduled bin.
module ddc_plan_sched
    import ddc_plan_pkg::*;
(
    input  logic             dev_clk,
    input  logic             reset,
    ddc_plan_sched_if.slave  bus
);

    plan_state_t state_q, state_d;
    logic        sel_q, sel_d;
    plan_len_t   shadow_len_q, shadow_len_d;
    plan_len_t   active_len_q, active_len_d;
    plan_len_t   ptr_q, ptr_d;
    plan_k_t     last_k_q, last_k_d;
    logic        pending_q, pending_d;
    logic        ovf_q, ovf_d;
    logic        order_q, order_d;
    logic        hit_valid_q, hit_valid_d;
    plan_idx_t   hit_index_q, hit_index_d;
    logic        running_q, running_d;

    logic      frame_start;
    logic      swap_fire;
    logic      push_ok;
    logic      match_bank;
    plan_len_t match_len;
    plan_len_t ptr_eff;
    plan_k_t   rd_k;
    plan_k_t   rdata0, rdata1;

    assign frame_start = bus.valid_in && (bus.k_in == '0);

    // A clear in the same cycle cancels the pending commit, so it also suppresses the swap.
    assign swap_fire = pending_q && !bus.cfg_clear && ((state_q == ST_IDLE) || frame_start);

    // The frame-start sample that triggers a swap is matched against the incoming plan.
    assign match_bank = swap_fire ? ~sel_q : sel_q;
    assign match_len  = swap_fire ? shadow_len_q : active_len_q;
    assign ptr_eff    = frame_start ? '0 : ptr_q;
    assign rd_k       = match_bank ? rdata1 : rdata0;

    assign push_ok = bus.cfg_wr && !bus.cfg_clear && !pending_q
                   && (shadow_len_q < LEN_W'(N_PLAN));

    // Bank sel_q is active; the other one is the shadow receiving pushes.
    ddc_plan_bank u_bank0 (
        .clk_i     (dev_clk),
        .we_i      (push_ok && sel_q),
        .waddr_i   (shadow_len_q[IDX_W-1:0]),
        .wdata_i   (bus.cfg_k),
        .raddr_i   (ptr_eff[IDX_W-1:0]),
        .rdata_c_o (rdata0)
    );

    ddc_plan_bank u_bank1 (
        .clk_i     (dev_clk),
        .we_i      (push_ok && !sel_q),
        .waddr_i   (shadow_len_q[IDX_W-1:0]),
        .wdata_i   (bus.cfg_k),
        .raddr_i   (ptr_eff[IDX_W-1:0]),
        .rdata_c_o (rdata1)
    );

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        shadow_len_d = shadow_len_q;
        active_len_d = active_len_q;
        ptr_d        = ptr_q;
        last_k_d     = last_k_q;
        pending_d    = pending_q;
        ovf_d        = ovf_q;
        order_d      = order_q;
        hit_valid_d  = 1'b0;
        hit_index_d  = hit_index_q;

        case (state_q)
            ST_IDLE: begin
                if (swap_fire) begin
                    state_d = ST_RUN;
                    ptr_d   = '0;
                end
            end
            ST_RUN: begin
                if (bus.valid_in) begin
                    ptr_d = ptr_eff;
                    if (ptr_eff < match_len) begin
                        if (bus.k_in == rd_k) begin
                            hit_valid_d = 1'b1;
                            hit_index_d = ptr_eff[IDX_W-1:0];
                            ptr_d       = ptr_eff + LEN_W'(1);
                        end else if (bus.k_in > rd_k) begin
                            ptr_d = ptr_eff + LEN_W'(1);
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Shadow-bank configuration; clear dominates push and commit.
        if (bus.cfg_clear) begin
            shadow_len_d = '0;
            ovf_d        = 1'b0;
            order_d      = 1'b0;
            pending_d    = 1'b0;
        end else begin
            if (bus.cfg_wr && !pending_q) begin
                if (shadow_len_q == LEN_W'(N_PLAN)) begin
                    ovf_d = 1'b1;
                end else begin
                    if ((shadow_len_q != '0) && (bus.cfg_k <= last_k_q)) begin
                        order_d = 1'b1;
                    end
                    last_k_d     = bus.cfg_k;
                    shadow_len_d = shadow_len_q + LEN_W'(1);
                end
            end
            if (bus.cfg_commit && (shadow_len_q != '0) && !order_q) begin
                pending_d = 1'b1;
            end
        end

        if (swap_fire) begin
            sel_d        = ~sel_q;
            active_len_d = shadow_len_q;
            shadow_len_d = '0;
            pending_d    = 1'b0;
        end

        running_d = (state_d == ST_RUN);
    end

    always_ff @(posedge dev_clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            sel_q        <= 1'b0;
            shadow_len_q <= '0;
            active_len_q <= '0;
            ptr_q        <= '0;
            last_k_q     <= '0;
            pending_q    <= 1'b0;
            ovf_q        <= 1'b0;
            order_q      <= 1'b0;
            hit_valid_q  <= 1'b0;
            hit_index_q  <= '0;
            running_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            shadow_len_q <= shadow_len_d;
            active_len_q <= active_len_d;
            ptr_q        <= ptr_d;
            last_k_q     <= last_k_d;
            pending_q    <= pending_d;
            ovf_q        <= ovf_d;
            order_q      <= order_d;
            hit_valid_q  <= hit_valid_d;
            hit_index_q  <= hit_index_d;
            running_q    <= running_d;
        end
    end

    assign bus.hit_valid    = hit_valid_q;
    assign bus.hit_index    = hit_index_q;
    assign bus.running      = running_q;
    assign bus.swap_pending = pending_q;
    assign bus.shadow_len   = shadow_len_q;
    assign bus.active_len   = active_len_q;
    assign bus.ovf_err      = ovf_q;
    assign bus.order_err    = order_q;

endmodule

// File: tb/tb_ddc_plan_sched.sv
// Bench for ddc_plan_sched: queue-based plan model checked every cycle, plus directed scenarios.
module tb_ddc_plan_sched;

    localparam int NP = 128;

    logic clk;
    logic rst;

    ddc_plan_sched_if bus ();

    ddc_plan_sched dut (
        .dev_clk (clk),
        .reset   (rst),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int m_shadow[$];
    int m_active[$];
    bit m_pend, m_run, m_ovf, m_ord, m_hv;
    int m_idx, m_ptr;

    // Log of observed hits: sample k and reported index
    int hit_k[$];
    int hit_i[$];

    function automatic void chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_shadow.delete();
        m_active.delete();
        m_pend = 0; m_run = 0; m_ovf = 0; m_ord = 0; m_hv = 0;
        m_idx = 0; m_ptr = 0;
    endfunction

    function automatic void model_step(input bit wr, input int k, input bit clr,
                                       input bit cm, input bit vin, input int kin);
        int  lst[$];
        int  p;
        bit  fire;
        int  olen;
        bit  opend, oord, orun;
        olen  = m_shadow.size();
        opend = m_pend;
        oord  = m_ord;
        orun  = m_run;
        fire  = opend && !clr && (!orun || (vin && kin == 0));
        m_hv  = 0;
        if (orun && vin) begin
            if (fire) lst = m_shadow;
            else      lst = m_active;
            p = (kin == 0) ? 0 : m_ptr;
            if (p < lst.size()) begin
                if (kin == lst[p]) begin
                    m_hv  = 1;
                    m_idx = p;
                    p++;
                end else if (kin > lst[p]) begin
                    p++;
                end
            end
            m_ptr = p;
        end
        if (clr) begin
            m_shadow.delete();
            m_ovf = 0; m_ord = 0; m_pend = 0;
        end else begin
            if (wr && !opend) begin
                if (olen == NP) m_ovf = 1;
                else begin
                    if (olen > 0 && k <= m_shadow[olen-1]) m_ord = 1;
                    m_shadow.push_back(k);
                end
            end
            if (cm && olen > 0 && !oord) m_pend = 1;
        end
        if (fire) begin
            m_active = m_shadow;
            m_shadow.delete();
            m_pend = 0;
            if (!orun) m_ptr = 0;
            m_run = 1;
        end
    endfunction

    // Model update at each edge, full output compare 1 time unit later
    always @(posedge clk) begin : model_proc
        bit s_rst, s_wr, s_clr, s_cm, s_vin;
        int s_k, s_kin;
        s_rst = rst;
        s_wr  = bus.cfg_wr;
        s_k   = int'(bus.cfg_k);
        s_clr = bus.cfg_clear;
        s_cm  = bus.cfg_commit;
        s_vin = bus.valid_in;
        s_kin = int'(bus.k_in);
        if (s_rst) model_reset();
        else       model_step(s_wr, s_k, s_clr, s_cm, s_vin, s_kin);
        #1;
        chk("hit_valid",    int'(bus.hit_valid),    int'(m_hv));
        chk("hit_index",    int'(bus.hit_index),    m_idx);
        chk("running",      int'(bus.running),      int'(m_run));
        chk("swap_pending", int'(bus.swap_pending), int'(m_pend));
        chk("shadow_len",   int'(bus.shadow_len),   m_shadow.size());
        chk("active_len",   int'(bus.active_len),   m_active.size());
        chk("ovf_err",      int'(bus.ovf_err),      int'(m_ovf));
        chk("order_err",    int'(bus.order_err),    int'(m_ord));
        if (bus.hit_valid === 1'b1) begin
            hit_k.push_back(s_kin);
            hit_i.push_back(int'(bus.hit_index));
        end
    end

    // Drive one cycle of inputs (called at a negedge, returns at the next negedge)
    task automatic tick(input bit r, input bit wr, input int k, input bit clr,
                        input bit cm, input bit vin, input int kin);
        rst            = r;
        bus.cfg_wr     = wr;
        bus.cfg_k      = 14'(k);
        bus.cfg_clear  = clr;
        bus.cfg_commit = cm;
        bus.valid_in   = vin;
        bus.k_in       = 14'(kin);
        @(negedge clk);
    endtask

    task automatic idle();           tick(0, 0, 0, 0, 0, 0, 0); endtask
    task automatic push(input int k); tick(0, 1, k, 0, 0, 0, 0); endtask
    task automatic commit();         tick(0, 0, 0, 0, 1, 0, 0); endtask
    task automatic clear();          tick(0, 0, 0, 1, 0, 0, 0); endtask
    task automatic sample(input int k); tick(0, 0, 0, 0, 0, 1, k); endtask
    task automatic do_reset();       tick(1, 0, 0, 0, 0, 0, 0); endtask

    task automatic expect_hit(input string tag, input int n, input int k, input int idx);
        chk({tag, "_hit_k"},   (n < hit_k.size()) ? hit_k[n] : -1, k);
        chk({tag, "_hit_idx"}, (n < hit_i.size()) ? hit_i[n] : -1, idx);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_hv"},   int'(bus.hit_valid),    0);
        chk({tag, "_hidx"}, int'(bus.hit_index),    0);
        chk({tag, "_run"},  int'(bus.running),      0);
        chk({tag, "_pend"}, int'(bus.swap_pending), 0);
        chk({tag, "_slen"}, int'(bus.shadow_len),   0);
        chk({tag, "_alen"}, int'(bus.active_len),   0);
        chk({tag, "_ovf"},  int'(bus.ovf_err),      0);
        chk({tag, "_ord"},  int'(bus.order_err),    0);
    endtask

    initial begin
        int fk, flen, rk, kin, ck;
        bit vin, wr, cm, clr, r;

        rst = 1'b1;
        bus.cfg_wr = 0; bus.cfg_k = '0; bus.cfg_clear = 0; bus.cfg_commit = 0;
        bus.valid_in = 0; bus.k_in = '0;
        @(negedge clk);
        do_reset();
        do_reset();
        check_all_zero("reset");

        // Load and commit from IDLE
        push(3); push(5); push(9);
        chk("t1_slen", int'(bus.shadow_len), 3);
        commit();
        chk("t1_pend", int'(bus.swap_pending), 1);
        idle();
        hit_k.delete(); hit_i.delete();
        for (int k = 0; k < 16; k++) sample(k);
        idle();
        chk("t1_running", int'(bus.running), 1);
        chk("t1_alen", int'(bus.active_len), 3);
        chk("t1_nhits", hit_k.size(), 3);
        expect_hit("t1_0", 0, 3, 0);
        expect_hit("t1_1", 1, 5, 1);
        expect_hit("t1_2", 2, 9, 2);

        // Frame-boundary swap: running {3}, load {4}
        do_reset();
        push(3); commit(); idle();
        hit_k.delete(); hit_i.delete();
        for (int k = 0; k < 8; k++) sample(k);
        expect_hit("t2_a", 0, 3, 0);
        push(4); commit();
        chk("t2_pend_a", int'(bus.swap_pending), 1);
        hit_k.delete(); hit_i.delete();
        for (int k = 5; k <= 20; k++) sample(k);
        chk("t2_pend_b", int'(bus.swap_pending), 1);
        for (int k = 0; k < 8; k++) sample(k);
        idle();
        chk("t2_pend_c", int'(bus.swap_pending), 0);
        chk("t2_nhits", hit_k.size(), 1);
        expect_hit("t2_b", 0, 4, 0);

        // Missed entry
        do_reset();
        push(2); push(3); push(6); commit(); idle();
        hit_k.delete(); hit_i.delete();
        sample(0); sample(1); sample(2); sample(4); sample(5); sample(6);
        idle();
        chk("t3_nhits", hit_k.size(), 2);
        expect_hit("t3_0", 0, 2, 0);
        expect_hit("t3_1", 1, 6, 2);

        // Overflow
        do_reset();
        for (int i = 0; i < 129; i++) push(i + 1);
        chk("t4_slen", int'(bus.shadow_len), 128);
        chk("t4_ovf", int'(bus.ovf_err), 1);
        clear();
        chk("t4_slen_clr", int'(bus.shadow_len), 0);
        chk("t4_ovf_clr", int'(bus.ovf_err), 0);

        // Order error blocks commit
        do_reset();
        push(10); push(7);
        chk("t5_ord", int'(bus.order_err), 1);
        commit();
        chk("t5_pend", int'(bus.swap_pending), 0);

        // Reset mid-frame
        do_reset();
        push(1); push(2); commit(); idle();
        sample(0); sample(1);
        tick(1, 0, 0, 0, 0, 1, 2);
        check_all_zero("t6");
        hit_k.delete(); hit_i.delete();
        for (int k = 0; k < 6; k++) sample(k);
        chk("t6_nhits", hit_k.size(), 0);

        // Randomized traffic
        do_reset();
        fk = 0; flen = 20; rk = 1;
        for (int c = 0; c < 3000; c++) begin
            r   = ($urandom % 600) == 0;
            clr = ($urandom % 80) == 0;
            cm  = ($urandom % 20) == 0;
            wr  = ($urandom % 6) == 0;
            if (($urandom % 12) == 0) ck = int'($urandom % 48);
            else begin
                rk = rk + 1 + int'($urandom % 3);
                ck = rk;
            end
            if (clr || cm || rk > 60) rk = int'($urandom % 4);
            vin = ($urandom % 4) != 0;
            if (($urandom % 16) == 0) kin = int'($urandom % 48);
            else kin = fk;
            if (vin) begin
                fk++;
                if (fk > flen) begin
                    fk = 0;
                    flen = 8 + int'($urandom % 50);
                end
            end
            tick(r, wr, ck, clr, cm, vin, kin);
        end
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
